sdm_modulator: RTL and testbench

//  Second-order digital delta-sigma modulator: converts signed PCM samples at
//  the decimated rate into a 1-bit oversampled stream, one bit per clk.

---
 rtl/sdm_modulator.sv | 167 ++++++++++++++++
 tb/tb_sdm_modulator.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdm_modulator.sv
// sdm_modulator: second-order delta-sigma modulator.
// Converts signed PCM samples (one per OSR clocks) into a 1-bit stream,
// one bit per clk. Both integrators saturate; they never wrap.
// Optional feature macro: DITHER_EN adds a 16-bit LFSR dither term to the
// quantizer input. The default build (macro undefined) has no dither and is
// fully deterministic.
//
// Input handshake (valid/ready): a sample transfers on any rising clk edge
// where din_valid and din_ready are both high. din_ready depends only on
// internal state (buffer empty, or frame boundary this cycle), never on
// din_valid. The source must hold din stable while din_valid is high and
// din_ready is low.
module sdm_modulator #(
  parameter int DATA_W = 16,
  parameter int OSR    = 128,
  parameter int ACC_W  = DATA_W + 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     out,
  output logic                     underrun
);

  localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
  // Two guard bits: i + x - y and i2 + i1n - y cannot overflow this width.
  localparam int SUM_W = ACC_W + 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

  localparam logic signed [SUM_W-1:0] FS_POS  = SUM_W'(longint'(1) <<< (DATA_W - 1));
  localparam logic signed [SUM_W-1:0] FS_NEG  = SUM_W'(-(longint'(1) <<< (DATA_W - 1)));
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((longint'(1) <<< (ACC_W - 1)) - longint'(1));
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(longint'(1) <<< (ACC_W - 1)));

  // Rate counter and frame tick
  logic [CNT_W-1:0] cnt;
  logic             tick;

  // One-entry input buffer and the sample currently being modulated
  logic                     pend;
  logic signed [DATA_W-1:0] buf_q;
  logic signed [DATA_W-1:0] x_q;
  logic                     accept;

  // Integrators
  logic signed [ACC_W-1:0] i1;
  logic signed [ACC_W-1:0] i2;

  // Combinational datapath
  logic signed [SUM_W-1:0] x_ext;
  logic signed [SUM_W-1:0] i1_ext;
  logic signed [SUM_W-1:0] i2_ext;
  logic signed [SUM_W-1:0] y_ext;
  logic signed [SUM_W-1:0] s1;
  logic signed [SUM_W-1:0] s2;
  logic signed [ACC_W-1:0] i1n;
  logic signed [ACC_W-1:0] i2n;
  logic signed [SUM_W-1:0] i1n_ext;
  logic signed [SUM_W-1:0] i2n_ext;
  logic signed [SUM_W-1:0] d_ext;
  logic signed [SUM_W-1:0] dec;
  logic                    out_next;

  // Clamp a wide sum into the integrator range.
  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] s);
    logic signed [ACC_W-1:0] r;
    if (s > SAT_MAX) begin
      r = SAT_MAX[ACC_W-1:0];
    end else if (s < SAT_MIN) begin
      r = SAT_MIN[ACC_W-1:0];
    end else begin
      r = s[ACC_W-1:0];
    end
    return r;
  endfunction

  assign tick      = (cnt == CNT_LAST);
  assign din_ready = ~pend | tick;
  assign accept    = din_valid & din_ready;

  // Free-running frame counter, wraps after OSR clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Input buffer: accept into buf_q, hand buf_q to x_q on the frame tick.
  // A tick with an empty buffer keeps x_q and flags an underrun; a sample
  // arriving on that same tick still lands in buf_q for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      buf_q    <= '0;
      x_q      <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= tick & ~pend;
      if (accept) begin
        buf_q <= din;
      end
      if (tick) begin
        if (pend) begin
          x_q <= buf_q;
        end
        pend <= accept;
      end else if (accept) begin
        pend <= 1'b1;
      end
    end
  end

`ifdef DITHER_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, advances every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  // Dither is the low five LFSR bits read as a signed value (-16..15).
  assign d_ext = {{(SUM_W - 5){lfsr[4]}}, lfsr[4:0]};
`else
  assign d_ext = '0;
`endif

  // Loop filter: two saturating integrators fed back by the previous bit.
  always_comb begin
    x_ext    = {{(SUM_W - DATA_W){x_q[DATA_W-1]}}, x_q};
    i1_ext   = {{(SUM_W - ACC_W){i1[ACC_W-1]}}, i1};
    i2_ext   = {{(SUM_W - ACC_W){i2[ACC_W-1]}}, i2};
    y_ext    = out ? FS_POS : FS_NEG;
    s1       = i1_ext + x_ext - y_ext;
    i1n      = sat(s1);
    i1n_ext  = {{(SUM_W - ACC_W){i1n[ACC_W-1]}}, i1n};
    s2       = i2_ext + i1n_ext - y_ext;
    i2n      = sat(s2);
    i2n_ext  = {{(SUM_W - ACC_W){i2n[ACC_W-1]}}, i2n};
    dec      = i2n_ext + d_ext;
    out_next = ~dec[SUM_W-1];
  end

  // Register integrator state and the quantized output bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1  <= '0;
      i2  <= '0;
      out <= 1'b0;
    end else begin
      i1  <= i1n;
      i2  <= i2n;
      out <= out_next;
    end
  end

endmodule

// File: tb/tb_sdm_modulator.sv
// Testbench for sdm_modulator: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the modulator.
module tb_sdm_modulator;

  localparam int     DATA_W  = 16;
  localparam int     OSR     = 128;
  localparam int     ACC_W   = DATA_W + 4;
  localparam longint FS      = longint'(1) <<< (DATA_W - 1);
  localparam longint SAT_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint SAT_MIN = -(longint'(1) <<< (ACC_W - 1));

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              din_ready;
  logic              out;
  logic              underrun;

  always #5 clk = ~clk;

  sdm_modulator #(.DATA_W(DATA_W), .OSR(OSR), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .out       (out),
    .underrun  (underrun)
  );

  // ---------------- scoreboard / model ----------------
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [DATA_W-1:0] exp_q[$];   // samples waiting to become the active input
  int     m_cnt;                 // position inside the current frame
  longint m_x;
  longint m_i1;
  longint m_i2;
  bit     m_out;
  bit     m_under;
  logic [15:0] m_lfsr;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  function automatic longint clampv(input longint v);
    if (v > SAT_MAX) return SAT_MAX;
    if (v < SAT_MIN) return SAT_MIN;
    return v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_cnt   = 0;
    m_x     = 0;
    m_i1    = 0;
    m_i2    = 0;
    m_out   = 1'b0;
    m_under = 1'b0;
    m_lfsr  = 16'hACE1;
  endtask

  // One clock of the modulator, straight from the arithmetic rules.
  task automatic model_step();
    bit                 tick;
    bit                 rdy;
    bit                 acc;
    longint             y;
    longint             d;
    longint             n1;
    longint             n2;
    logic signed [DATA_W-1:0] s;
    logic signed [4:0]  ds;
    tick = (m_cnt == OSR - 1);
    rdy  = (exp_q.size() == 0) || tick;
    acc  = din_valid && rdy;
    y    = m_out ? FS : -FS;
    d    = 0;
`ifdef DITHER_EN
    ds = m_lfsr[4:0];
    d  = longint'(ds);
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
    n1    = clampv(m_i1 + m_x - y);
    n2    = clampv(m_i2 + n1 - y);
    m_i1  = n1;
    m_i2  = n2;
    m_out = (n2 + d) >= 0;
    m_under = 1'b0;
    if (tick) begin
      if (exp_q.size() > 0) begin
        s   = exp_q.pop_front();
        m_x = longint'(s);
      end else begin
        m_under = 1'b1;
      end
    end
    if (acc) exp_q.push_back(din);
    m_cnt = tick ? 0 : m_cnt + 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare process: outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("out", out, m_out);
        check("underrun", underrun, m_under);
        check("din_ready", din_ready, (exp_q.size() == 0) || (m_cnt == OSR - 1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int ns);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    #(ns);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic count_ones(input int n, output int ones, output int unders);
    ones   = 0;
    unders = 0;
    repeat (n) begin
      @(negedge clk);
      ones   += int'(out);
      unders += int'(underrun);
    end
  endtask

  task automatic check_idle_pattern(input string name);
    // x = 0 from reset: bits after each of the first eight edges.
    logic [7:0] pat;
    pat = 8'b1101_0011;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) din_valid = 1'b0;
`ifndef DITHER_EN
      check(name, out, pat[7-k]);
`endif
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int ones;
    int unders;
    int acc;
    int p;

    // Reset values while rst_n is held low.
    rst_n = 1'b0;
    #500;
    check("rst_out", out, 0);
    check("rst_din_ready", din_ready, 1);
    check("rst_underrun", underrun, 0);
    chk_en = 1'b1;

    // Idle: no samples, x stays 0.
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_pattern("idle_seq");
    n = 8;
    while (!underrun && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("first_underrun_cycle", n, 128);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!underrun && n < 300);
    check("underrun_period", n, 128);
    count_ones(128, ones, unders);
    check_range("idle_density", ones, 63, 65);
    check("idle_underruns_per_frame", unders, 1);

    // Constant +0.5 FS, then -0.5 FS, source always valid.
    din = 16'h4000;
    din_valid = 1'b1;
    count_ones(3 * OSR, ones, unders);
    count_ones(4 * OSR, ones, unders);
    check_range("density_4000", ones, 376, 392);
    check("underruns_4000", unders, 0);
    din = 16'hC000;
    count_ones(3 * OSR, ones, unders);
    count_ones(4 * OSR, ones, unders);
    check_range("density_C000", ones, 120, 136);
    check("underruns_C000", unders, 0);

    // Accept cadence with din_valid held high from reset release.
    do_reset(40);
    din = 16'h1234;
    din_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 4 * OSR; i++) begin
      #1;
      if (din_ready && din_valid) acc++;
      @(negedge clk);
    end
    check("accepts_4frames", acc, 5);

    // Full-scale input drives the integrators into saturation, then 0.
    do_reset(40);
    din = 16'h7FFF;
    din_valid = 1'b1;
    count_ones(9 * OSR, ones, unders);
    count_ones(OSR, ones, unders);
    check_range("fullscale_ones", ones, 127, 128);
    din = 16'h0000;
    count_ones(5 * OSR, ones, unders);
    count_ones(OSR, ones, unders);
    check_range("recovery_density", ones, 62, 66);

    // Mid-frame asynchronous reset with a sample pending.
    do_reset(40);
    din = 16'h3000;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (40) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out", out, 0);
    check("midrst_underrun", underrun, 0);
    check("midrst_din_ready", din_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    din = 16'h2000;
    din_valid = 1'b1;
    check_idle_pattern("post_rst_seq");
    count_ones(3 * OSR, ones, unders);

    // Randomized traffic, with one asynchronous reset in the middle.
    for (int f = 0; f < 25; f++) begin
      p = $urandom_range(0, 100);
      if (f == 12) begin
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      repeat (OSR) begin
        @(negedge clk);
        if (!(din_valid && !din_ready)) begin
          din_valid = ($urandom_range(0, 99) < p);
          if (f % 5 == 4) din = DATA_W'($urandom_range(0, 65535));
          else din = DATA_W'(int'($urandom_range(0, 49152)) - 24576);
        end
      end
    end
    din_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #5ms;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
